// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and E-stage forwarding control for the five-stage core,
// driven from a shadow copy of the E/M/W occupants plus saturating perf counters.
module hazard_unit #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validD,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rdD,
  input  logic            use1D,
  input  logic            use2D,
  input  logic            regwriteD,
  input  logic            loadD,
  input  logic            pcsrcE,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic [CNTW-1:0] stallcnt,
  output logic [CNTW-1:0] flushcnt
);

  logic       eV, eRw, eLd, eU1, eU2;
  logic [4:0] eRd, eRs1, eRs2;
  logic       mV, mRw;
  logic [4:0] mRd;
  logic       wV, wRw;
  logic [4:0] wRd;

  logic lwhaz;
  logic mWritesA, mWritesB, wWritesA, wWritesB;

  // x0 is hardwired zero, so a record targeting it never produces a hazard or a forward.
  assign mWritesA = mV & mRw & (mRd == eRs1) & (mRd != 5'd0);
  assign mWritesB = mV & mRw & (mRd == eRs2) & (mRd != 5'd0);
  assign wWritesA = wV & wRw & (wRd == eRs1) & (wRd != 5'd0);
  assign wWritesB = wV & wRw & (wRd == eRs2) & (wRd != 5'd0);

  assign lwhaz = eV & eLd & eRw & (eRd != 5'd0) &
                 validD & ((use1D & (rs1D == eRd)) | (use2D & (rs2D == eRd)));

  // A taken branch makes the D instruction wrong-path, so it overrides the load stall.
  assign stallD = lwhaz & ~pcsrcE;
  assign stallF = stallD;
  assign flushD = pcsrcE & reset;
  assign flushE = (lwhaz | pcsrcE) & reset;

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (eU1 & mWritesA)      forwardAE = 2'b10;
    else if (eU1 & wWritesA) forwardAE = 2'b01;
    if (eU2 & mWritesB)      forwardBE = 2'b10;
    else if (eU2 & wWritesB) forwardBE = 2'b01;
  end

  // The M load flag has no consumer in this unit, so only v/rd/rw move down from E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eV <= 1'b0; eRd <= 5'd0; eRw <= 1'b0; eLd <= 1'b0;
      eRs1 <= 5'd0; eRs2 <= 5'd0; eU1 <= 1'b0; eU2 <= 1'b0;
      mV <= 1'b0; mRd <= 5'd0; mRw <= 1'b0;
      wV <= 1'b0; wRd <= 5'd0; wRw <= 1'b0;
    end else begin
      wV  <= mV;
      wRd <= mRd;
      wRw <= mRw;
      mV  <= eV;
      mRd <= eRd;
      mRw <= eRw;
      if (flushE) begin
        eV <= 1'b0; eRd <= 5'd0; eRw <= 1'b0; eLd <= 1'b0;
        eRs1 <= 5'd0; eRs2 <= 5'd0; eU1 <= 1'b0; eU2 <= 1'b0;
      end else begin
        eV   <= validD;
        eRd  <= rdD;
        eRw  <= regwriteD;
        eLd  <= loadD;
        eRs1 <= rs1D;
        eRs2 <= rs2D;
        eU1  <= use1D;
        eU2  <= use2D;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallcnt <= '0;
      flushcnt <= '0;
    end else begin
      if (stallD && (stallcnt != {CNTW{1'b1}}))
        stallcnt <= stallcnt + CNTW'(1);
      if (pcsrcE && (flushcnt != {CNTW{1'b1}}))
        flushcnt <= flushcnt + CNTW'(1);
    end
  end

endmodule
